max_pool_2x2: RTL and testbench

//  Stride-2 2x2 signed max-pooling stage that sits directly downstream of the 1x1 convolution

---
 rtl/max_pool_2x2.sv | 110 +++++++++++
 tb/tb_max_pool_2x2.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// Stride-2 2x2 signed max pool over a row-major valid-qualified pixel stream; outputs registered,
// 1 cycle after the 4th window pixel. No backpressure: a pixel may arrive every cycle.
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_SIZE   = 256
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [8:0]                   image_size,
  input  logic                         pi_data_valid,
  input  logic signed [DATA_WIDTH-1:0] pi_data,
  output logic                         po_data_valid,
  output logic signed [DATA_WIDTH-1:0] po_data,
  output logic                         po_frame_done,
  output logic                         po_cfg_err
);

  localparam int LB_DEPTH = MAX_SIZE / 2;
  localparam int AW       = $clog2(LB_DEPTH);
  localparam logic [9:0] MAX_SZ = 10'(MAX_SIZE);

  logic [8:0]                   col_q, col_d, row_q, row_d, size_q, size_d;
  logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                         vld_q, vld_d, done_q, done_d, err_q, err_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic signed [DATA_WIDTH-1:0] lbuf_q [LB_DEPTH];

  logic                         frame_start, size_bad, lb_we;
  logic [AW-1:0]                lb_idx;
  logic signed [DATA_WIDTH-1:0] h_max, lb_rd, pooled;

  assign frame_start = (col_q == 9'd0) && (row_q == 9'd0);
  assign size_bad    = (image_size < 9'd2) || ({1'b0, image_size} > MAX_SZ);
  assign lb_idx      = col_q[AW:1];
  assign lb_rd       = lbuf_q[lb_idx];
  assign h_max       = (pair_q > pi_data) ? pair_q : pi_data;
  assign pooled      = (lb_rd > h_max) ? lb_rd : h_max;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    size_d = size_q;
    pair_d = pair_q;
    data_d = data_q;
    vld_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    lb_we  = 1'b0;
    if (pi_data_valid) begin
      if (frame_start && size_bad) begin
        // Counters stay at zero so the following pixel re-samples the size.
        err_d = 1'b1;
      end else begin
        if (frame_start) size_d = image_size;
        if (!col_q[0]) begin
          pair_d = pi_data;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          vld_d  = 1'b1;
          data_d = pooled;
        end
        if (col_q == size_d - 9'd1) begin
          col_d = 9'd0;
          if (row_q == size_d - 9'd1) begin
            row_d  = 9'd0;
            done_d = 1'b1;
          end else begin
            row_d = row_q + 9'd1;
          end
        end else begin
          col_d = col_q + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      size_q <= '0;
      pair_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      size_q <= size_d;
      pair_q <= pair_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Not reset: every even row rewrites an entry before the odd row reads it.
  always_ff @(posedge sys_clk) begin
    if (lb_we) lbuf_q[lb_idx] <= h_max;
  end

  assign po_data_valid = vld_q;
  assign po_data       = data_q;
  assign po_frame_done = done_q;
  assign po_cfg_err    = err_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: directed frames push expected events, a monitor pops them.
module tb_max_pool_2x2;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [8:0]         image_size;
  logic               pi_data_valid;
  logic signed [15:0] pi_data;
  logic               po_data_valid;
  logic signed [15:0] po_data;
  logic               po_frame_done;
  logic               po_cfg_err;

  always #5 sys_clk = ~sys_clk;

  max_pool_2x2 #(.DATA_WIDTH(16), .MAX_SIZE(256)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .image_size    (image_size),
    .pi_data_valid (pi_data_valid),
    .pi_data       (pi_data),
    .po_data_valid (po_data_valid),
    .po_data       (po_data),
    .po_frame_done (po_frame_done),
    .po_cfg_err    (po_cfg_err)
  );

  typedef struct packed {
    logic               vld;
    logic               done;
    logic               err;
    logic signed [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every DUT output event must match the oldest expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge sys_clk);
      if (mon_en && (po_data_valid || po_frame_done || po_cfg_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("po_data_valid", int'(po_data_valid), int'(e.vld));
          chk("po_frame_done", int'(po_frame_done), int'(e.done));
          chk("po_cfg_err", int'(po_cfg_err), int'(e.err));
          if (e.vld) chk("po_data", int'(po_data), int'(e.data));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      pi_data_valid = 1'b0;
      pi_data       = 16'sh7fff;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic drive(input logic [8:0] sz, input logic signed [15:0] d, input int gaps,
                       input logic ev, input logic signed [15:0] ed, input logic edn,
                       input logic eer);
    idle(gaps);
    pi_data_valid = 1'b1;
    pi_data       = d;
    image_size    = sz;
    if (ev || edn || eer) exp_q.push_back('{vld: ev, done: edn, err: eer, data: ed});
    @(posedge sys_clk); #1;
    pi_data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    idle(4);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Size-4 ramp 0..15: outputs equal the pixel at indices 5,7,13,15; later size changes ignored.
  task automatic frame_ramp4(input bit gappy);
    for (int i = 0; i < 16; i++)
      drive((i == 0) ? 9'd4 : 9'd7, 16'(i), gappy ? int'($urandom_range(0, 1)) : 0,
            (i == 5 || i == 7 || i == 13 || i == 15), 16'(i), (i == 15), 1'b0);
  endtask

  initial begin
    sys_rst       = 1'b1;
    image_size    = 9'd0;
    pi_data_valid = 1'b0;
    pi_data       = 16'sd0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_valid", int'(po_data_valid), 0);
    chk("reset_data", int'(po_data), 0);
    chk("reset_done", int'(po_frame_done), 0);
    chk("reset_err", int'(po_cfg_err), 0);
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    frame_ramp4(1'b0);
    drain("ramp4_drained");

    // All -5 except one most-negative pixel: every window max is -5.
    for (int i = 0; i < 16; i++)
      drive(9'd4, (i == 10) ? -16'sd32768 : -16'sd5, 0,
            (i == 5 || i == 7 || i == 13 || i == 15), -16'sd5, (i == 15), 1'b0);
    drain("neg4_drained");

    // Odd size 5: windows end at 6,8,16,18; last row/column dropped; done after pixel 24.
    for (int i = 0; i < 25; i++)
      drive(9'd5, 16'(i), 0, (i == 6 || i == 8 || i == 16 || i == 18), 16'(i), (i == 24), 1'b0);
    drain("odd5_drained");

    // Random gaps, then back-to-back size-2 frame 3,-1,7,2 -> 7.
    frame_ramp4(1'b1);
    drive(9'd2, 16'sd3, 0, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, -16'sd1, 0, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, 16'sd7, 0, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, 16'sd2, 0, 1'b1, 16'sd7, 1'b1, 1'b0);
    drain("gap_b2b_drained");

    // Illegal sizes 1, 0, 300 each drop a pixel; then a legal size-2 frame 1,2,3,4 -> 4.
    drive(9'd1, 16'sd9, 0, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(9'd0, 16'sd9, 0, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(9'd300, 16'sd9, 0, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(9'd2, 16'sd1, 1, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, 16'sd2, 0, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, 16'sd3, 0, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(9'd2, 16'sd4, 0, 1'b1, 16'sd4, 1'b1, 1'b0);
    drain("cfg_err_drained");

    // Reset after pixel 9 of a size-4 frame, then a clean frame.
    for (int i = 0; i < 10; i++)
      drive(9'd4, 16'(i), 0, (i == 5 || i == 7), 16'(i), 1'b0, 1'b0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    chk("midrst_valid", int'(po_data_valid), 0);
    chk("midrst_data", int'(po_data), 0);
    drain("midrst_partial_drained");
    frame_ramp4(1'b0);
    drain("post_reset_drained");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
